// File: rtl/rf_pkg.sv
// Purpose: shared defaults, opcode and FSM state encodings for the register-file initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_COPY  = 2'b10,
    OP_ADD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10,
    S_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/rf_initiator.sv
// Purpose: sequences one WRITE/READ/COPY/ADD command at a time onto a register file's ports.
// Latency: accept edge to rsp_valid = 2 cycles (READ) or 3 cycles (WRITE/COPY/ADD).
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: cmd_* command channel (valid/ready), rf_* register-file master ports
//        (two async reads, one sync write), rsp_* response channel, ops_done counter.
module rf_initiator
  import rf_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [WIDTH-1:0]  rf_read_data1,
  input  logic [WIDTH-1:0]  rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [WIDTH-1:0]  rf_write_data,
  output logic              rf_we,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data1,
  output logic [WIDTH-1:0]  rsp_data2,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  ops_done
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0]    imm_q, d1_q, d2_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                rsp_hs;
  logic [WIDTH:0]      add_sum;

  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign rsp_hs  = (state_q == S_RESP) && rsp_ready;
  // One extra bit keeps the carry out of the addition.
  assign add_sum = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_READ) ? S_RESP : S_WB;
      S_WB:    state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        rd_q  <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        imm_q <= cmd_data;
      end
      // Read ports are driven from latched addresses during EXEC, so the
      // async read data is settled by the capturing edge.
      if (state_q == S_EXEC) begin
        case (op_q)
          OP_WRITE: begin d1_q <= imm_q;              d2_q <= '0;            end
          OP_READ:  begin d1_q <= rf_read_data1;      d2_q <= rf_read_data2; end
          OP_COPY:  begin d1_q <= rf_read_data1;      d2_q <= '0;            end
          default:  begin
            d1_q <= add_sum[WIDTH-1:0];
            d2_q <= {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
          end
        endcase
      end
      // Register 0 is not writable; flag the attempt instead.
      if ((state_q == S_WB) && (rd_q == '0)) err_q <= 1'b1;
      if (rsp_hs) begin
        err_q <= 1'b0;
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs are forced to zero while rst is high so an interrupted WB cannot
  // land a write in the register file.
  always_comb begin
    cmd_ready     = 1'b0;
    rf_read_reg1  = '0;
    rf_read_reg2  = '0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_we         = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data1     = '0;
    rsp_data2     = '0;
    rsp_err       = 1'b0;
    ops_done      = '0;
    if (!rst) begin
      ops_done = cnt_q;
      case (state_q)
        S_IDLE: cmd_ready = 1'b1;
        S_EXEC: begin
          rf_read_reg1 = rs1_q;
          rf_read_reg2 = rs2_q;
        end
        S_WB: begin
          rf_write_reg  = rd_q;
          rf_write_data = d1_q;
          rf_we         = (rd_q != '0);
        end
        S_RESP: begin
          rsp_valid = 1'b1;
          rsp_data1 = d1_q;
          rsp_data2 = d2_q;
          rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_initiator.sv
module tb_rf_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] cmd_data;
  logic [2:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [3:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic       rf_we;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [3:0] rsp_data1, rsp_data2;
  logic [7:0] ops_done;

  int n_checks = 0;
  int n_err    = 0;

  // Environment register file: async reads, write at rising edge.
  logic [3:0] rf_mem [8];
  logic       rf_clr;
  assign rf_read_data1 = rf_mem[rf_read_reg1];
  assign rf_read_data2 = rf_mem[rf_read_reg2];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 4'h0;
    end else if (rf_we) begin
      rf_mem[rf_write_reg] <= rf_write_data;
    end
  end

  // Reference model state.
  logic [3:0] ref_regs [8];
  logic [7:0] ops_exp;

  always #5 clk = ~clk;

  rf_initiator #(.WIDTH(4), .ADDR_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_data(cmd_data),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_we(rf_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'($urandom);
    cmd_op    = 2'($urandom);
    cmd_rd    = 3'($urandom);
    cmd_rs1   = 3'($urandom);
    cmd_rs2   = 3'($urandom);
    cmd_data  = 4'($urandom);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_idle", {31'b0, cmd_ready}, 1);
  endtask

  // Issue one command, observe port activity and response, update the model.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [3:0] dat, input int hold);
    int a, b, lat, cyc, we_cnt, we_cyc;
    logic [3:0] e1, e2, we_dat;
    logic [2:0] we_reg;
    logic ee, ewr;
    a = int'(ref_regs[rs1]);
    b = int'(ref_regs[rs2]);
    e2 = 4'h0;
    case (op)
      2'b00: e1 = dat;
      2'b01: begin e1 = ref_regs[rs1]; e2 = ref_regs[rs2]; end
      2'b10: e1 = ref_regs[rs1];
      default: begin e1 = 4'((a + b) % 16); e2 = 4'((a + b) / 16); end
    endcase
    ee  = (op != 2'b01) && (rd == 3'd0);
    ewr = (op != 2'b01) && (rd != 3'd0);
    lat = (op == 2'b01) ? 2 : 3;

    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_data = dat;
    @(negedge clk);
    scramble_cmd();
    cyc = 1; we_cnt = 0; we_cyc = 0; we_reg = 3'd0; we_dat = 4'h0;
    while (!rsp_valid && cyc < 10) begin
      if (cyc == 1) begin
        check("rd_port1", {29'b0, rf_read_reg1}, {29'b0, rs1});
        check("rd_port2", {29'b0, rf_read_reg2}, {29'b0, rs2});
      end
      check("cmd_ready_busy", {31'b0, cmd_ready}, 0);
      if (rf_we) begin
        we_cnt++; we_cyc = cyc; we_reg = rf_write_reg; we_dat = rf_write_data;
      end
      @(negedge clk);
      scramble_cmd();
      cyc++;
    end
    check("latency", cyc, lat);
    check("we_count", we_cnt, ewr ? 1 : 0);
    if (ewr) begin
      check("we_cycle", we_cyc, 2);
      check("we_reg", {29'b0, we_reg}, {29'b0, rd});
      check("we_data", {28'b0, we_dat}, {28'b0, e1});
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", {31'b0, rsp_valid}, 1);
      check("hold_data1", {28'b0, rsp_data1}, {28'b0, e1});
      check("hold_ready", {31'b0, cmd_ready}, 0);
      check("hold_we", {31'b0, rf_we}, 0);
      @(negedge clk);
      scramble_cmd();
    end
    check("rsp_data1", {28'b0, rsp_data1}, {28'b0, e1});
    check("rsp_data2", {28'b0, rsp_data2}, {28'b0, e2});
    check("rsp_err", {31'b0, rsp_err}, {31'b0, ee});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    ops_exp = ops_exp + 8'd1;
    check("ops_done", {24'b0, ops_done}, {24'b0, ops_exp});
    check("rsp_valid_drop", {31'b0, rsp_valid}, 0);
    if (ewr) ref_regs[rd] = e1;
  endtask

  initial begin
    rst = 1'b1; rf_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_data = 4'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 4'h0;
    ops_exp = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_we", {31'b0, rf_we}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_ops", {24'b0, ops_done}, 0);
    rst = 1'b0; rf_clr = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, cmd_ready}, 1);
    @(negedge clk);

    run_cmd(2'b00, 3'd3, 3'd0, 3'd0, 4'hA, 0);  // WRITE R3=A
    run_cmd(2'b00, 3'd1, 3'd0, 3'd0, 4'h5, 0);  // WRITE R1=5
    run_cmd(2'b00, 3'd2, 3'd0, 3'd0, 4'hC, 1);  // WRITE R2=C
    run_cmd(2'b01, 3'd0, 3'd1, 3'd2, 4'h0, 0);  // READ 5,C
    run_cmd(2'b11, 3'd4, 3'd1, 3'd2, 4'h0, 0);  // ADD -> 1 carry 1
    run_cmd(2'b01, 3'd0, 3'd4, 3'd4, 4'h0, 0);  // READ R4
    run_cmd(2'b00, 3'd0, 3'd0, 3'd0, 4'hF, 0);  // WRITE R0 -> err
    run_cmd(2'b01, 3'd0, 3'd0, 3'd3, 4'h0, 0);  // READ R0 = 0, err cleared
    run_cmd(2'b10, 3'd6, 3'd4, 3'd0, 4'h0, 5);  // COPY with 5-cycle stall

    // Reset during WB of COPY rd=5: write must not land, no response.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rd = 3'd5; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0; cmd_data = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wb_we_before_rst", {31'b0, rf_we}, 1);
    rst = 1'b1;
    #1;
    check("rst_we_gated", {31'b0, rf_we}, 0);
    @(negedge clk);
    check("midrst_ops", {24'b0, ops_done}, 0);
    check("midrst_valid", {31'b0, rsp_valid}, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'b0, cmd_ready}, 1);
    check("midrst_we", {31'b0, rf_we}, 0);
    check("r5_unchanged", {28'b0, rf_mem[5]}, {28'b0, ref_regs[5]});
    ops_exp = 8'd0;
    @(negedge clk);

    // Random traffic; enough commands to wrap the 8-bit counter.
    for (int n = 0; n < 300; n++) begin
      run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 8; i++) check("final_reg", {28'b0, rf_mem[i]}, {28'b0, ref_regs[i]});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
